// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_access_ctrl_pkg;

    localparam int BE_WIDTH = 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        RESP
    } t_dmem_state;

endpackage

// File: rtl/dmem_access_ctrl_store_lane_mux.sv
// Store lane replication, byte enables and misalignment from size/offset.
module dmem_access_ctrl_store_lane_mux
    import dmem_access_ctrl_pkg::*;
(
    input  logic [1:0]          size,
    input  logic [2:0]          off,
    input  logic [63:0]         data,
    output logic [63:0]         wdata,
    output logic [BE_WIDTH-1:0] be,
    output logic                ma
);

    always_comb begin
        wdata = data;
        be    = '1;
        ma    = 1'b0;
        unique case (size)
            F3_B[1:0]: begin
                wdata = {8{data[7:0]}};
                be    = 8'h01 << off;
            end
            F3_H[1:0]: begin
                wdata = {4{data[15:0]}};
                be    = 8'h03 << off;
                ma    = off[0];
            end
            F3_W[1:0]: begin
                wdata = {2{data[31:0]}};
                be    = 8'h0F << off;
                ma    = |off[1:0];
            end
            F3_D[1:0]: begin
                wdata = data;
                be    = 8'hFF;
                ma    = |off;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Memory-stage controller: one memory transaction per load/store.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  i_req_valid,
    input  logic                  i_req_we,
    input  logic [2:0]            i_func3,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_store_data,
    output logic                  o_stall,
    output logic                  o_resp_valid,
    output logic [DATA_WIDTH-1:0] o_load_data,
    output logic [2:0]            o_load_func3,
    output logic [2:0]            o_load_addr_offset,
    output logic                  o_store_addr_ma,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [BE_WIDTH-1:0]   o_mem_be,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    t_dmem_state state, state_nxt;

    logic                  we_q;
    logic [2:0]            func3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BE_WIDTH-1:0]   be_q;
    logic                  ma_q;
    logic [DATA_WIDTH-1:0] ld_data_q;
    logic [2:0]            ld_func3_q;
    logic [2:0]            ld_off_q;

    logic [DATA_WIDTH-1:0] lane_wdata;
    logic [BE_WIDTH-1:0]   lane_be;
    logic                  lane_ma;

    logic accept;
    logic capture;

    dmem_access_ctrl_store_lane_mux u_store_lane_mux (
        .size  (i_func3[1:0]),
        .off   (i_addr[2:0]),
        .data  (i_store_data),
        .wdata (lane_wdata),
        .be    (lane_be),
        .ma    (lane_ma)
    );

    assign accept  = (state == IDLE) && i_req_valid;
    assign capture = (state == WAIT_R) && i_mem_rvalid;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (i_req_valid) begin
                    state_nxt = (i_req_we && lane_ma) ? RESP : REQ;
                end
            end
            REQ: begin
                if (i_mem_req_ready) begin
                    state_nxt = we_q ? RESP : WAIT_R;
                end
            end
            WAIT_R: begin
                if (i_mem_rvalid) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        o_stall         = 1'b0;
        o_resp_valid    = 1'b0;
        o_mem_req_valid = 1'b0;
        unique case (state)
            IDLE:   o_stall = i_req_valid;
            REQ: begin
                o_stall         = 1'b1;
                o_mem_req_valid = 1'b1;
            end
            WAIT_R: o_stall = 1'b1;
            RESP:   o_resp_valid = 1'b1;
        endcase
    end

    // Loads always fetch the full doubleword; extraction happens downstream.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            we_q       <= 1'b0;
            func3_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            ma_q       <= 1'b0;
            ld_data_q  <= '0;
            ld_func3_q <= '0;
            ld_off_q   <= '0;
        end else begin
            if (accept) begin
                we_q    <= i_req_we;
                func3_q <= i_func3;
                addr_q  <= i_addr;
                wdata_q <= lane_wdata;
                be_q    <= i_req_we ? lane_be : '1;
                ma_q    <= i_req_we & lane_ma;
            end
            if (capture) begin
                ld_data_q  <= i_mem_rdata;
                ld_func3_q <= func3_q;
                ld_off_q   <= addr_q[2:0];
            end
        end
    end

    assign o_mem_addr         = {addr_q[ADDR_WIDTH-1:3], 3'b000};
    assign o_mem_we           = we_q;
    assign o_mem_wdata        = wdata_q;
    assign o_mem_be           = be_q;
    assign o_store_addr_ma    = ma_q;
    assign o_load_data        = ld_data_q;
    assign o_load_func3       = ld_func3_q;
    assign o_load_addr_offset = ld_off_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a delay-configurable memory.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        i_req_we = 1'b0;
    logic [2:0]  i_func3 = '0;
    logic [63:0] i_addr = '0;
    logic [63:0] i_store_data = '0;
    logic        o_stall;
    logic        o_resp_valid;
    logic [63:0] o_load_data;
    logic [2:0]  o_load_func3;
    logic [2:0]  o_load_addr_offset;
    logic        o_store_addr_ma;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready = 1'b0;
    logic [63:0] o_mem_addr;
    logic        o_mem_we;
    logic [63:0] o_mem_wdata;
    logic [7:0]  o_mem_be;
    logic        i_mem_rvalid = 1'b0;
    logic [63:0] i_mem_rdata = '0;

    dmem_access_ctrl #(
        .ADDR_WIDTH (64),
        .DATA_WIDTH (64)
    ) dut (
        .clk                (clk),
        .arst               (arst),
        .i_req_valid        (i_req_valid),
        .i_req_we           (i_req_we),
        .i_func3            (i_func3),
        .i_addr             (i_addr),
        .i_store_data       (i_store_data),
        .o_stall            (o_stall),
        .o_resp_valid       (o_resp_valid),
        .o_load_data        (o_load_data),
        .o_load_func3       (o_load_func3),
        .o_load_addr_offset (o_load_addr_offset),
        .o_store_addr_ma    (o_store_addr_ma),
        .o_mem_req_valid    (o_mem_req_valid),
        .i_mem_req_ready    (i_mem_req_ready),
        .o_mem_addr         (o_mem_addr),
        .o_mem_we           (o_mem_we),
        .o_mem_wdata        (o_mem_wdata),
        .o_mem_be           (o_mem_be),
        .i_mem_rvalid       (i_mem_rvalid),
        .i_mem_rdata        (i_mem_rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Memory responder: ready after rdy_dly request cycles, rvalid after
    // rv_dly cycles following the handshake cycle.
    bit          mem_auto = 1'b1;
    int          rdy_dly = 0;
    int          rv_dly = 0;
    logic [63:0] rd_word = '0;
    int          rq_cnt = 0;
    int          rv_cnt = 0;
    bit          rwait = 1'b0;

    always begin
        @(posedge clk);
        #1;
        if (mem_auto) begin
            i_mem_req_ready = 1'b0;
            i_mem_rvalid    = 1'b0;
            i_mem_rdata     = 64'hDEAD_DEAD_DEAD_DEAD;
            if (rwait) begin
                if (rv_cnt == rv_dly) begin
                    i_mem_rvalid = 1'b1;
                    i_mem_rdata  = rd_word;
                    rwait        = 1'b0;
                end else begin
                    rv_cnt++;
                end
            end
            if (o_mem_req_valid) begin
                if (rq_cnt == rdy_dly) begin
                    i_mem_req_ready = 1'b1;
                    rq_cnt = 0;
                    rv_cnt = 0;
                    rwait  = !o_mem_we;
                end else begin
                    rq_cnt++;
                end
            end
        end
    end

    // Called at posedge+1 of the request cycle; returns at posedge+1 of
    // the cycle after the response.
    task automatic run(input string nm, input logic we,
                       input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] sd, input logic [63:0] rd,
                       input int rdy, input int rv, input int exp_cyc,
                       input logic [63:0] e_wdata, input logic [7:0] e_be,
                       input int e_nreq, input logic e_ma, input bit hold);
        int nreq = 0;
        logic [63:0] e_addr;
        e_addr = addr & ~64'h7;
        rdy_dly = rdy;
        rv_dly  = rv;
        rd_word = rd;
        i_req_valid  = 1'b1;
        i_req_we     = we;
        i_func3      = f3;
        i_addr       = addr;
        i_store_data = sd;
        for (int c = 0; c <= exp_cyc; c++) begin
            @(negedge clk);
            chk({nm, ".stall"}, 64'(o_stall), 64'(c < exp_cyc));
            chk({nm, ".resp"}, 64'(o_resp_valid), 64'(c == exp_cyc));
            if (o_mem_req_valid) begin
                chk({nm, ".maddr"}, o_mem_addr, e_addr);
                chk({nm, ".mwe"}, 64'(o_mem_we), 64'(we));
                chk({nm, ".mbe"}, 64'(o_mem_be), 64'(e_be));
                if (we) chk({nm, ".wdata"}, o_mem_wdata, e_wdata);
                if (i_mem_req_ready) nreq++;
            end
            if (c == exp_cyc) begin
                chk({nm, ".ma"}, 64'(o_store_addr_ma), 64'(e_ma));
            end
            if (c < exp_cyc) begin
                @(posedge clk);
                #1;
            end
        end
        chk({nm, ".nreq"}, 64'(nreq), 64'(e_nreq));
        @(posedge clk);
        #1;
        if (!hold) i_req_valid = 1'b0;
    endtask

    task automatic chk_load(input string nm, input logic [63:0] d,
                            input logic [2:0] f3, input logic [2:0] off);
        chk({nm, ".ldata"}, o_load_data, d);
        chk({nm, ".lf3"}, 64'(o_load_func3), 64'(f3));
        chk({nm, ".loff"}, 64'(o_load_addr_offset), 64'(off));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.stall", 64'(o_stall), 64'd0);
        chk("rst.resp", 64'(o_resp_valid), 64'd0);
        chk("rst.mreq", 64'(o_mem_req_valid), 64'd0);
        chk("rst.ldata", o_load_data, 64'd0);
        chk("rst.ma", 64'(o_store_addr_ma), 64'd0);
        chk("rst.mbe", 64'(o_mem_be), 64'd0);
        arst = 1'b0;
        @(posedge clk);
        #1;

        run("lh", 1'b0, 3'b001, 64'h1006, 64'h0,
            64'h8877_6655_4433_2211, 0, 0, 3, 64'h0, 8'hFF, 1, 1'b0, 1'b0);
        chk_load("lh", 64'h8877_6655_4433_2211, 3'b001, 3'b110);

        run("sb", 1'b1, 3'b000, 64'h2003, 64'h1234_5678_9ABC_DEAB,
            64'h0, 0, 0, 2, 64'hABAB_ABAB_ABAB_ABAB, 8'h08, 1, 1'b0, 1'b0);
        chk("sb.ldhold", o_load_data, 64'h8877_6655_4433_2211);

        run("swma", 1'b1, 3'b010, 64'h2002, 64'h1111_2222,
            64'h0, 0, 0, 1, 64'h0, 8'h00, 0, 1'b1, 1'b0);

        run("sh", 1'b1, 3'b001, 64'h2006, 64'h0000_0000_0000_BEEF,
            64'h0, 0, 0, 2, 64'hBEEF_BEEF_BEEF_BEEF, 8'hC0, 1, 1'b0, 1'b0);

        run("sw6", 1'b1, 3'b110, 64'h2004, 64'h9999_9999_CAFE_F00D,
            64'h0, 1, 0, 3, 64'hCAFE_F00D_CAFE_F00D, 8'hF0, 1, 1'b0, 1'b0);

        run("sd", 1'b1, 3'b011, 64'h2008, 64'h0102_0304_0506_0708,
            64'h0, 0, 0, 2, 64'h0102_0304_0506_0708, 8'hFF, 1, 1'b0, 1'b0);

        run("sdma", 1'b1, 3'b011, 64'h200C, 64'h0,
            64'h0, 0, 0, 1, 64'h0, 8'h00, 0, 1'b1, 1'b0);

        run("shma", 1'b1, 3'b001, 64'h2001, 64'h0,
            64'h0, 0, 0, 1, 64'h0, 8'h00, 0, 1'b1, 1'b0);

        run("ldslow", 1'b0, 3'b011, 64'h3000, 64'h0,
            64'h0123_4567_89AB_CDEF, 3, 2, 8, 64'h0, 8'hFF, 1, 1'b0, 1'b0);
        chk_load("ldslow", 64'h0123_4567_89AB_CDEF, 3'b011, 3'b000);

        // Abort while the request is still pending.
        mem_auto = 1'b0;
        i_mem_req_ready = 1'b0;
        i_mem_rvalid = 1'b0;
        i_req_valid = 1'b1;
        i_req_we = 1'b0;
        i_func3 = 3'b011;
        i_addr = 64'h4000;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abq.mreq0", 64'(o_mem_req_valid), 64'd1);
        #1;
        arst = 1'b1;
        i_req_valid = 1'b0;
        #1;
        chk("abq.mreq", 64'(o_mem_req_valid), 64'd0);
        chk("abq.stall", 64'(o_stall), 64'd0);
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk);
        #1;

        // Abort while waiting for read data.
        i_req_valid = 1'b1;
        @(posedge clk);
        #1;
        i_mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        i_mem_req_ready = 1'b0;
        @(negedge clk);
        chk("abr.stall0", 64'(o_stall), 64'd1);
        #1;
        arst = 1'b1;
        i_req_valid = 1'b0;
        #1;
        chk("abr.mreq", 64'(o_mem_req_valid), 64'd0);
        chk("abr.resp", 64'(o_resp_valid), 64'd0);
        chk("abr.stall", 64'(o_stall), 64'd0);
        chk("abr.ldata", o_load_data, 64'd0);
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk);
        #1;
        i_mem_rvalid = 1'b1;
        i_mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("abr.lresp", 64'(o_resp_valid), 64'd0);
            chk("abr.lstall", 64'(o_stall), 64'd0);
            @(posedge clk);
            #1;
        end
        i_mem_rvalid = 1'b0;
        chk("abr.lldata", o_load_data, 64'd0);
        rq_cnt = 0;
        rv_cnt = 0;
        rwait = 1'b0;
        mem_auto = 1'b1;
        @(posedge clk);
        #1;

        run("lbpost", 1'b0, 3'b000, 64'h6001, 64'h0,
            64'hFFEE_DDCC_BBAA_9988, 0, 0, 3, 64'h0, 8'hFF, 1, 1'b0, 1'b0);
        chk_load("lbpost", 64'hFFEE_DDCC_BBAA_9988, 3'b000, 3'b001);

        // Back-to-back loads with the request held through RESP.
        run("b2b1", 1'b0, 3'b010, 64'h5004, 64'h0,
            64'h1111_2222_3333_4444, 0, 0, 3, 64'h0, 8'hFF, 1, 1'b0, 1'b1);
        chk_load("b2b1", 64'h1111_2222_3333_4444, 3'b010, 3'b100);
        run("b2b2", 1'b0, 3'b100, 64'h5007, 64'h0,
            64'h5555_6666_7777_8888, 0, 0, 3, 64'h0, 8'hFF, 1, 1'b0, 1'b0);
        chk_load("b2b2", 64'h5555_6666_7777_8888, 3'b100, 3'b111);

        @(negedge clk);
        chk("end.stall", 64'(o_stall), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
